// File: rtl/pipe_pkg.sv
// pipe_pkg: shared RV32I pipeline constants (opcodes, control-bit layout, ID/EX tag payload).
package pipe_pkg;

  localparam int unsigned CTRL_W  = 10;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  // Control word: {Branch,ALUSrc,RegWrite,ALUOp[1:0],MemRead,MemWrite,MemtoReg,Jump,1'b0}
  localparam int unsigned CTRL_BRANCH     = 9;
  localparam int unsigned CTRL_ALU_SRC    = 8;
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_ALU_OP_HI  = 6;
  localparam int unsigned CTRL_ALU_OP_LO  = 5;
  localparam int unsigned CTRL_MEM_READ   = 4;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_MEM_TO_REG = 2;
  localparam int unsigned CTRL_JUMP       = 1;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  // Non-operand part of the EX slot; all-zero is a bubble.
  typedef struct packed {
    logic               valid;
    logic [CTRL_W-1:0]  ctrl;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [FUNCT_W-1:0] funct;
  } ex_tag_t;

  // True for opcodes that read rs2 (R-type, store, branch).
  function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX boundary.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  import pipe_pkg::*;

  logic                 id_valid_i;
  logic [31:0]          id_instr_i;
  logic [XLEN-1:0]      id_pc_i;
  logic [XLEN-1:0]      id_rs1_data_i;
  logic [XLEN-1:0]      id_rs2_data_i;
  logic [XLEN-1:0]      id_imm_i;
  logic [CTRL_W-1:0]    id_ctrl_i;
  logic                 flush_i;
  logic                 hold_i;
  logic                 stall_o;
  logic                 ex_valid_o;
  logic [CTRL_W-1:0]    ex_ctrl_o;
  logic [XLEN-1:0]      ex_pc_o;
  logic [XLEN-1:0]      ex_rs1_data_o;
  logic [XLEN-1:0]      ex_rs2_data_o;
  logic [XLEN-1:0]      ex_imm_o;
  logic [REG_W-1:0]     ex_rd_o;
  logic [REG_W-1:0]     ex_rs1_o;
  logic [REG_W-1:0]     ex_rs2_o;
  logic [FUNCT_W-1:0]   ex_funct_o;

  modport master (
    output id_valid_i, id_instr_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_ctrl_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_imm_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_funct_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_ctrl_i, flush_i, hold_i,
    output stall_o, ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_imm_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_funct_o
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose rd is read by the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [OPC_W-1:0] id_opcode_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             hold_i,
  output logic             stall_o
);

  logic uses_rs1_c;
  logic uses_rs2_c;
  logic match_c;

  // Hazard compare; suppressed under hold since IF/ID is already frozen by that path.
  always_comb begin
    uses_rs1_c = (id_opcode_i != OP_JAL);
    uses_rs2_c = uses_rs2(id_opcode_i);
    match_c    = (uses_rs1_c && (id_rs1_i == ex_rd_i)) ||
                 (uses_rs2_c && (id_rs2_i == ex_rd_i));
    stall_o    = !hold_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                 id_valid_i && match_c;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush squash and hold.
// Optional saturating hazard counters when ID_EX_HAZARD_STATS_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  parameter int unsigned STAT_W = 16
`endif
) (
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] flush_cnt_o
`endif
);

  ex_tag_t         tag_q, tag_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            stall_c;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^{bus.id_instr_i[31], bus.id_instr_i[29:25]};

  load_use_detect u_detect (
    .ex_valid_i   (tag_q.valid),
    .ex_mem_read_i(tag_q.ctrl[CTRL_MEM_READ]),
    .ex_rd_i      (tag_q.rd),
    .id_valid_i   (bus.id_valid_i),
    .id_opcode_i  (bus.id_instr_i[6:0]),
    .id_rs1_i     (bus.id_instr_i[19:15]),
    .id_rs2_i     (bus.id_instr_i[24:20]),
    .hold_i       (bus.hold_i),
    .stall_o      (stall_c)
  );

  // Next EX slot: flush > hold > load-use bubble > normal load.
  always_comb begin
    tag_d      = tag_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (bus.flush_i) begin
      tag_d      = '0;
      tag_d.ctrl = BUBBLE_CTRL;
    end else if (!bus.hold_i) begin
      if (stall_c) begin
        tag_d      = '0;
        tag_d.ctrl = BUBBLE_CTRL;
      end else begin
        tag_d.valid = bus.id_valid_i;
        tag_d.ctrl  = bus.id_valid_i ? bus.id_ctrl_i : BUBBLE_CTRL;
        tag_d.rd    = bus.id_instr_i[11:7];
        tag_d.rs1   = bus.id_instr_i[19:15];
        tag_d.rs2   = bus.id_instr_i[24:20];
        tag_d.funct = {bus.id_instr_i[30], bus.id_instr_i[14:12]};
        pc_d        = bus.id_pc_i;
        rs1_data_d  = bus.id_rs1_data_i;
        rs2_data_d  = bus.id_rs2_data_i;
        imm_d       = bus.id_imm_i;
      end
    end
  end

  // EX slot register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q      <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      tag_q      <= tag_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  assign bus.stall_o       = stall_c;
  assign bus.ex_valid_o    = tag_q.valid;
  assign bus.ex_ctrl_o     = tag_q.ctrl;
  assign bus.ex_rd_o       = tag_q.rd;
  assign bus.ex_rs1_o      = tag_q.rs1;
  assign bus.ex_rs2_o      = tag_q.rs2;
  assign bus.ex_funct_o    = tag_q.funct;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_imm_o      = imm_q;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Count taken flushes and taken load-use bubbles, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush_i) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + STAT_W'(1);
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
